// File: rtl/reg_alu_n_pkg.sv
// Shared definitions for the registered multi-cycle ALU: opcode encodings,
// controller state encoding and flag bit positions within {V,N,Z,C}.
package reg_alu_n_pkg;

    localparam logic [3:0] OP_TRANSFER = 4'h0;
    localparam logic [3:0] OP_INC      = 4'h1;
    localparam logic [3:0] OP_ADD      = 4'h2;
    localparam logic [3:0] OP_ADC      = 4'h3;
    localparam logic [3:0] OP_SUB      = 4'h4;
    localparam logic [3:0] OP_SBB      = 4'h5;
    localparam logic [3:0] OP_DEC      = 4'h6;
    localparam logic [3:0] OP_PASS_B   = 4'h7;
    localparam logic [3:0] OP_AND      = 4'h8;
    localparam logic [3:0] OP_OR       = 4'h9;
    localparam logic [3:0] OP_XOR      = 4'hA;
    localparam logic [3:0] OP_NOT      = 4'hB;
    localparam logic [3:0] OP_SHL      = 4'hC;
    localparam logic [3:0] OP_SHR      = 4'hD;
    localparam logic [3:0] OP_ASR      = 4'hE;
    localparam logic [3:0] OP_MUL      = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/reg_alu_n_adder.sv
// adder_n: WIDTH-bit ripple-carry adder shared by the arithmetic ops and the
// multiply accumulate step.
module adder_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

// File: rtl/reg_alu_n.sv
// reg_alu_n: registered WIDTH-bit ALU with valid/ready handshakes.
// Single-cycle arithmetic/logic ops, iterative shifts (one bit per cycle) and
// an optional shift-add multiplier enabled by the ALU_MUL_EN macro. Without
// ALU_MUL_EN, opcode F completes at once with result=0, flags=0, err=1.
module reg_alu_n
    import reg_alu_n_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;   // counter must reach WIDTH for multiply

    alu_state_e       state_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] work_reg;     // shift operand, or multiplier/low product
    logic [CW-1:0]    cnt_reg;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;
`endif

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cin;
    logic             add_cout;

    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] res_now;
    logic [3:0]       flags_now;
    logic             c_now;
    logic             v_now;
    logic             err_now;
    logic             multi_now;
    logic             clear_flags;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;

    function automatic logic [3:0] pack_flags(input logic v, input logic [WIDTH-1:0] r,
                                              input logic c);
        logic [3:0] f;
        f[FLAG_V] = v;
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        return f;
    endfunction

    assign sh_amt    = b[SHW-1:0];
    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);

    adder_n #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Adder operand select: accumulate step while multiplying, else the op on the inputs
    always_comb begin
        add_a   = a;
        add_b   = '0;
        add_cin = 1'b0;
`ifdef ALU_MUL_EN
        if (state_reg == ST_BUSY) begin
            add_a = hi_reg;
            add_b = work_reg[0] ? mcand_reg : '0;
        end else begin
`else
        begin
`endif
            case (op)
                OP_INC: add_cin = 1'b1;
                OP_ADD: add_b = b;
                OP_ADC: begin add_b = b;  add_cin = cin;  end
                OP_SUB: begin add_b = ~b; add_cin = 1'b1; end
                OP_SBB: begin add_b = ~b; add_cin = cin;  end
                OP_DEC: add_b = '1;
                default: ;
            endcase
        end
    end

`ifdef ALU_MUL_EN
    // Shift-add step: {carry, hi+addend, lo} shifted right by one
    assign hi_step = {add_cout, add_sum[WIDTH-1:1]};
    assign lo_step = {add_sum[0], work_reg[WIDTH-1:1]};
`endif

    // Result and flags of an op completing at the accept edge
    always_comb begin
        res_now     = '0;
        c_now       = 1'b0;
        v_now       = 1'b0;
        err_now     = 1'b0;
        multi_now   = 1'b0;
        clear_flags = 1'b0;
        case (op)
            OP_TRANSFER, OP_INC, OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_DEC: begin
                res_now = add_sum;
                c_now   = add_cout;
                v_now   = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != add_a[WIDTH-1]);
            end
            OP_PASS_B: res_now = b;
            OP_AND:    res_now = a & b;
            OP_OR:     res_now = a | b;
            OP_XOR:    res_now = a ^ b;
            OP_NOT:    res_now = ~a;
            OP_SHL, OP_SHR, OP_ASR: begin
                if (sh_amt == '0) res_now = a;
                else              multi_now = 1'b1;
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
                multi_now = 1'b1;
`else
                err_now     = 1'b1;
                clear_flags = 1'b1;
`endif
            end
            default: ;
        endcase
        flags_now = clear_flags ? 4'b0000 : pack_flags(v_now, res_now, c_now);
    end

    // One-bit shift of the working operand; step_bit is the bit leaving it
    always_comb begin
        step_val = work_reg;
        step_bit = 1'b0;
        case (op_reg)
            OP_SHL: begin step_val = {work_reg[WIDTH-2:0], 1'b0};          step_bit = work_reg[WIDTH-1]; end
            OP_SHR: begin step_val = {1'b0, work_reg[WIDTH-1:1]};          step_bit = work_reg[0];       end
            OP_ASR: begin step_val = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]}; step_bit = work_reg[0];   end
            default: ;
        endcase
    end

    // Controller: accept in IDLE, iterate in BUSY, hold the result in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            work_reg  <= '0;
            cnt_reg   <= '0;
            result    <= '0;
            flags     <= '0;
            err       <= 1'b0;
`ifdef ALU_MUL_EN
            mcand_reg <= '0;
            hi_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_reg <= op;
                        if (multi_now) begin
                            state_reg <= ST_BUSY;
                            work_reg  <= a;
                            cnt_reg   <= CW'(sh_amt);
`ifdef ALU_MUL_EN
                            if (op == OP_MUL) begin
                                work_reg  <= b;
                                mcand_reg <= a;
                                hi_reg    <= '0;
                                cnt_reg   <= CW'(WIDTH);
                            end
`endif
                        end else begin
                            result    <= res_now;
                            flags     <= flags_now;
                            err       <= err_now;
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    cnt_reg  <= cnt_reg - CW'(1);
                    work_reg <= step_val;
`ifdef ALU_MUL_EN
                    if (op_reg == OP_MUL) begin
                        work_reg <= lo_step;
                        hi_reg   <= hi_step;
                    end
`endif
                    // Outputs change only on the final step, never mid-iteration
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= ST_DONE;
                        err       <= 1'b0;
                        result    <= step_val;
                        flags     <= pack_flags(1'b0, step_val, step_bit);
`ifdef ALU_MUL_EN
                        if (op_reg == OP_MUL) begin
                            result <= lo_step;
                            flags  <= pack_flags(1'b0, lo_step, |hi_step);
                        end
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_alu_n.sv
// Self-checking bench for reg_alu_n (WIDTH=8): behavioural reference model,
// per-cycle compare process, directed literal cases and randomized ops.
module tb_reg_alu_n;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         err;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int checks = 0;
    int failures = 0;

    bit         chk_en = 1'b0;
    bit         pending = 1'b0;
    int         remaining = 0;
    logic [7:0] exp_r = '0;
    logic [3:0] exp_f = '0;
    logic       exp_e = 1'b0;

    reg_alu_n #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic oor(input int t);
        return (t > 127) || (t < -128);
    endfunction

    // Reference: what an op must produce, from plain integer arithmetic
    function automatic void model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                  input logic ci, output logic [7:0] r, output logic [3:0] f,
                                  output logic e, output int lat);
        int ux, uy, sx, sy, ic, n, s, p;
        logic c, v;
        ux = x; uy = y; ic = ci;
        sx = $signed(x); sy = $signed(y);
        n = int'(y[2:0]);
        c = 1'b0; v = 1'b0; e = 1'b0; lat = 1; s = 0; r = '0;
        case (o)
            4'h0: begin s = ux;           c = 1'b0;        v = 1'b0;               r = s[7:0]; end
            4'h1: begin s = ux + 1;       c = (s > 255);   v = oor(sx + 1);        r = s[7:0]; end
            4'h2: begin s = ux + uy;      c = (s > 255);   v = oor(sx + sy);       r = s[7:0]; end
            4'h3: begin s = ux + uy + ic; c = (s > 255);   v = oor(sx + sy + ic);  r = s[7:0]; end
            4'h4: begin s = ux - uy;      c = (s >= 0);    v = oor(sx - sy);       r = s[7:0]; end
            4'h5: begin s = ux - uy - (1 - ic); c = (s >= 0); v = oor(sx - sy - (1 - ic)); r = s[7:0]; end
            4'h6: begin s = ux - 1;       c = (ux != 0);   v = oor(sx - 1);        r = s[7:0]; end
            4'h7: r = y;
            4'h8: r = x & y;
            4'h9: r = x | y;
            4'hA: r = x ^ y;
            4'hB: r = ~x;
            4'hC: begin r = x << n; c = (n > 0) ? x[8-n] : 1'b0; lat = (n > 0) ? n + 1 : 1; end
            4'hD: begin r = x >> n; c = (n > 0) ? x[n-1] : 1'b0; lat = (n > 0) ? n + 1 : 1; end
            4'hE: begin r = 8'($signed(x) >>> n); c = (n > 0) ? x[n-1] : 1'b0; lat = (n > 0) ? n + 1 : 1; end
            default: begin
`ifdef ALU_MUL_EN
                p = ux * uy; r = p[7:0]; c = (p > 255); lat = 9;
`else
                p = 0; r = 8'h00; e = 1'b1; lat = 1;
`endif
            end
        endcase
        f = {v, r[7], (r == 8'h00), c};
        if (e) f = 4'b0000;
    endfunction

    // Per-cycle compare of the handshake and, when valid, the result fields
    always @(negedge clk) begin
        if (chk_en) begin
            if (!pending) begin
                chk("in_ready_idle", in_ready, 1);
                chk("out_valid_idle", out_valid, 0);
            end else begin
                remaining = remaining - 1;
                chk("in_ready_busy", in_ready, 0);
                chk("out_valid", out_valid, remaining <= 0);
                if (remaining <= 0) begin
                    chk("result", result, exp_r);
                    chk("flags", flags, exp_f);
                    chk("err", err, exp_e);
                    if (out_ready) pending = 1'b0;
                end
            end
        end
    end

    // Issue one op; random ignored traffic while busy; out_ready held low bp cycles past valid
    task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input int bp);
        int lat, guard;
        in_valid = 1'b1; op = o; a = x; b = y; cin = ci; out_ready = 1'b0;
        @(posedge clk);
        model(o, x, y, ci, exp_r, exp_f, exp_e, lat);
        remaining = lat;
        pending = 1'b1;
        #1;
        guard = 0;
        while (pending && guard < 200) begin
            in_valid  = 1'($urandom_range(0, 1));
            op        = 4'($urandom);
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            out_ready = (guard >= lat - 1 + bp) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            guard++;
        end
        if (pending) begin
            checks++;
            failures++;
            $display("FAIL handshake_timeout: got pending expected consumed");
            pending = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [3:0] o, input logic [7:0] x,
                           input logic [7:0] y, input logic ci, input logic [7:0] er,
                           input logic [3:0] ef, input logic ee, input int el, input int bp);
        logic [7:0] r;
        logic [3:0] f;
        logic       e;
        int         lat;
        model(o, x, y, ci, r, f, e, lat);
        chk({name, "_model_result"}, r, er);
        chk({name, "_model_flags"}, f, ef);
        chk({name, "_model_err"}, e, ee);
        chk({name, "_model_latency"}, lat, el);
        run_op(o, x, y, ci, bp);
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, "_in_ready"}, in_ready, 1);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_result"}, result, 0);
        chk({name, "_flags"}, flags, 0);
        chk({name, "_err"}, err, 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #11;
        chk_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        directed("add_f0_20",  4'h2, 8'hF0, 8'h20, 1'b0, 8'h10, 4'b0001, 1'b0, 1, 0);
        directed("add_7f_01",  4'h2, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100, 1'b0, 1, 0);
        directed("sub_05_05",  4'h4, 8'h05, 8'h05, 1'b0, 8'h00, 4'b0011, 1'b0, 1, 0);
        directed("shl_81_3",   4'hC, 8'h81, 8'h03, 1'b0, 8'h08, 4'b0000, 1'b0, 4, 0);
        directed("asr_80_2",   4'hE, 8'h80, 8'h02, 1'b0, 8'hE0, 4'b0100, 1'b0, 3, 0);
        directed("shr_cnt0",   4'hD, 8'h5A, 8'h08, 1'b0, 8'h5A, 4'b0000, 1'b0, 1, 0);
        directed("dec_00",     4'h6, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0100, 1'b0, 1, 0);
        directed("inc_ff",     4'h1, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b0011, 1'b0, 1, 0);
        directed("sbb_10_20",  4'h5, 8'h10, 8'h20, 1'b0, 8'hEF, 4'b0100, 1'b0, 1, 0);
        directed("adc_80_80",  4'h3, 8'h80, 8'h80, 1'b1, 8'h01, 4'b1001, 1'b0, 1, 0);
`ifdef ALU_MUL_EN
        directed("mul_0c_0b",  4'hF, 8'h0C, 8'h0B, 1'b0, 8'h84, 4'b0100, 1'b0, 9, 0);
        directed("mul_10_10",  4'hF, 8'h10, 8'h10, 1'b0, 8'h00, 4'b0011, 1'b0, 9, 0);
`else
        directed("mul_off",    4'hF, 8'h0C, 8'h0B, 1'b0, 8'h00, 4'b0000, 1'b1, 1, 0);
`endif
        directed("backpress",  4'h2, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100, 1'b0, 1, 5);

        // Abandon a multi-cycle op with an asynchronous reset in its third busy cycle
        in_valid = 1'b1; a = 8'h0C; b = 8'h0B; cin = 1'b0; out_ready = 1'b0;
`ifdef ALU_MUL_EN
        op = 4'hF;
`else
        op = 4'hC; b = 8'h07;
`endif
        @(posedge clk);
        begin
            int lat;
            model(op, a, b, cin, exp_r, exp_f, exp_e, lat);
            remaining = lat;
        end
        pending = 1'b1;
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset_values("mid_busy_reset");
        pending = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        chk("post_reset_out_valid", out_valid, 0);
        chk_en = 1'b1;
        directed("add_after_rst", 4'h2, 8'h12, 8'h34, 1'b0, 8'h46, 4'b0000, 1'b0, 1, 0);

        for (int i = 0; i < 150; i++) begin
            run_op(4'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)));
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_alu_n.md
Name: reg_alu_n

Overview:
Parametrised, registered, multi-cycle ALU; next generation of the 4-bit registered ALU in the CPU datapath. Supports WIDTH-bit arithmetic and logic, iterative shifts and multiply, and registered C/Z/N/V flags. Valid/ready handshakes on input and output let the decoder FSM issue ops and stall on multi-cycle results.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of 2)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an op (high only in IDLE)
op  input  4  opcode (encodings in cpu_defs)
a  input  WIDTH  operand A
b  input  WIDTH  operand B / shift amount in b[SHW-1:0]
cin  input  1  carry in for ADC/SBB
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
flags  output  4  registered {V,N,Z,C}
err  output  1  illegal op flagged with the current result

Behaviour:
- Reset (rst=0, async): state=IDLE; result=0, flags=0, err=0, out_valid=0, shift counter=0; in_ready=1 during and after reset.
- Opcodes: 0 TRANSFER(a), 1 INC(a+1), 2 ADD(a+b), 3 ADC(a+b+cin), 4 SUB(a+~b+1), 5 SBB(a+~b+cin), 6 DEC(a+all-ones), 7 PASS_B, 8 AND, 9 OR, A XOR, B NOT(~a), C SHL, D SHR(logical), E ASR, F MUL.
- Arithmetic ops 0-6 use one shared WIDTH-bit ripple adder; C = adder carry-out; V = signed overflow of the adder operands as applied. Logic ops 7-B: C=0, V=0.
- Z = (result==0); N = result[WIDTH-1]; all flags set on every completed op.
- FSM states IDLE, BUSY, DONE.
- IDLE: in_valid&in_ready accepts op and latches a, b, op, cin.
  - Single-cycle op, or shift with count 0: result/flags registered at the accept edge -> DONE; out_valid high the cycle after accept.
  - Shift with count n>0, or MUL: -> BUSY.
- BUSY, shift: one bit per cycle for n cycles; C = last bit shifted out (ASR shifts in sign bit). Count-0 shift: result=a, C=0.
- BUSY, MUL: shift-add for WIDTH cycles; result = low WIDTH bits of a*b (unsigned); C = OR of high half; V=0.
- Multi-cycle latency: out_valid high n+1 cycles after accept (n = shift count or WIDTH).
- DONE: out_valid=1; result/flags/err held stable until out_valid&out_ready; then -> IDLE (in_ready=1 next cycle). Minimum issue interval 2 cycles.
- in_valid during BUSY/DONE is ignored: no latch, no side effects.
- Reset mid-BUSY or mid-DONE abandons the op; no partial result is ever made visible.

Optional Feature:
ALU_MUL_EN
- Defined: MUL op as above; multiplier datapath built.
- Undefined: no multiplier datapath. op=F completes single-cycle with result=0, flags=0, err=1. err=0 for every other op in both builds.

Decomposition:
- cpu_defs holds opcode `defines, FSM state encodings and flag bit indices.
- One sub-module: adder_n (parametrised WIDTH ripple-carry adder: a, b, cin -> sum, cout), used by the arithmetic ops and the multiply accumulate step.

Test Plan:
- WIDTH=8, ADD a=F0 b=20 -> result=10, C=1, Z=0, V=0, out_valid one cycle after accept.
- ADD 7F+01 -> result=80, N=1, V=1, C=0; SUB 05-05 -> result=00, Z=1, C=1.
- SHL a=81 b=3 -> out_valid 4 cycles after accept, result=08, C=0; ASR a=80 b=2 -> result=E0, N=1.
- MUL 0C*0B -> result=84, C=0, after 9 cycles; MUL 10*10 -> result=00, Z=1, C=1; without ALU_MUL_EN -> result=00, err=1.
- Backpressure: out_ready low for 5 cycles after an ADD -> result/flags stable, in_ready=0, a new in_valid is ignored; raise out_ready -> IDLE next cycle.
- Assert rst low during MUL BUSY cycle 3 -> outputs return to reset values immediately; after release in_ready=1, out_valid=0, next ADD correct.
